// File: rtl/div_seq.sv
// div_seq: control sequencer for the bit-sliced restoring divider column.
// Produces one quotient bit every three clocks. Every output is a registered decode of the next state.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for Start; operands and sign flags sampled on accept
//   LOAD   | DIVL <= |Op1|, DIVH cleared, iteration count preset
//   SHIFT  | {DIVH,DIVL} shifted left one place, count decremented
//   TRIAL  | ACC <= DIVH - |Op2|; AccCout valid by the end of this cycle
//   COMMIT | restore-or-keep: DIVH <= ACC on no-borrow, quotient bit to DIVL[0]
//   FIX    | sign-corrected quotient and remainder loaded
//   DONE   | one-cycle completion pulse
module div_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic Clock,
   input  logic nReset,
   input  logic Test,
   input  logic Start,
   input  logic Signed,
   input  logic Op1Msb,
   input  logic Op2Msb,
   input  logic Op2Zero,
   input  logic AccCout,
   output logic LOAD_DIVL,
   output logic LOAD_DIVH,
   output logic LOAD_ACC,
   output logic LOAD_QUOT,
   output logic LOAD_REM,
   output logic DIVL_P,
   output logic DIVH_P,
   output logic DIVH_0_P,
   output logic INV_OP1,
   output logic OP1_INV_Cin,
   output logic INV_OP2,
   output logic ACC_Cin,
   output logic INV_RESULT,
   output logic RESULT_INV_Cin,
   output logic INV_REM,
   output logic Busy,
   output logic Done,
   output logic DivZero
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SHIFT  = 3'd2,
      S_TRIAL  = 3'd3,
      S_COMMIT = 3'd4,
      S_FIX    = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   typedef struct packed {
      logic load_divl;
      logic load_divh;
      logic load_acc;
      logic load_quot;
      logic load_rem;
      logic divl_p;
      logic divh_p;
      logic divh_0_p;
      logic inv_op1;
      logic op1_inv_cin;
      logic inv_op2;
      logic acc_cin;
      logic inv_result;
      logic result_inv_cin;
      logic inv_rem;
      logic done;
   } ctl_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_neg_a;
   logic             r_neg_b;
   logic             w_neg_a_nxt;
   logic             w_neg_b_nxt;
   logic             r_div_zero;
   logic             w_div_zero_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   ctl_t             r_ctl;
   ctl_t             w_ctl_nxt;
   ctl_t             w_ctl_out;
   logic             w_accept;

   assign w_accept = (r_state == S_IDLE) && Start;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state <= S_IDLE;
      end else if (!Test) begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (Start) begin
               w_next_state = Op2Zero ? S_DONE : S_LOAD;
            end
         end
         S_LOAD:   w_next_state = S_SHIFT;
         S_SHIFT:  w_next_state = S_TRIAL;
         S_TRIAL:  w_next_state = S_COMMIT;
         S_COMMIT: w_next_state = (r_cnt == '0) ? S_FIX : S_SHIFT;
         S_FIX:    w_next_state = S_DONE;
         S_DONE:   w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_cnt_nxt      = r_cnt;
      w_neg_a_nxt    = r_neg_a;
      w_neg_b_nxt    = r_neg_b;
      w_div_zero_nxt = r_div_zero;
      if (w_accept) begin
         w_neg_a_nxt    = Signed & Op1Msb;
         w_neg_b_nxt    = Signed & Op2Msb;
         w_div_zero_nxt = Op2Zero;
      end
      if (r_state == S_LOAD) begin
         w_cnt_nxt = CNT_W'(WIDTH);
      end else if (r_state == S_SHIFT) begin
         w_cnt_nxt = r_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_cnt      <= '0;
         r_neg_a    <= 1'b0;
         r_neg_b    <= 1'b0;
         r_div_zero <= 1'b0;
      end else if (!Test) begin
         r_cnt      <= w_cnt_nxt;
         r_neg_a    <= w_neg_a_nxt;
         r_neg_b    <= w_neg_b_nxt;
         r_div_zero <= w_div_zero_nxt;
      end
   end

   // Decode is taken from the next state so the strobes appear in the cycle
   // that state occupies; COMMIT picks up the trial carry at the TRIAL->COMMIT edge.
   always_comb begin
      w_ctl_nxt  = '0;
      w_busy_nxt = (w_next_state != S_IDLE);
      case (w_next_state)
         S_LOAD: begin
            w_ctl_nxt.load_divl   = 1'b1;
            w_ctl_nxt.divl_p      = 1'b0;
            w_ctl_nxt.inv_op1     = w_neg_a_nxt;
            w_ctl_nxt.op1_inv_cin = w_neg_a_nxt;
            w_ctl_nxt.load_divh   = 1'b1;
            w_ctl_nxt.divh_p      = 1'b1;
         end
         S_SHIFT: begin
            w_ctl_nxt.load_divh = 1'b1;
            w_ctl_nxt.divh_p    = 1'b1;
            w_ctl_nxt.load_divl = 1'b1;
            w_ctl_nxt.divl_p    = 1'b1;
            w_ctl_nxt.divh_0_p  = 1'b0;
         end
         S_TRIAL: begin
            w_ctl_nxt.load_acc = 1'b1;
            w_ctl_nxt.inv_op2  = ~w_neg_b_nxt;
            w_ctl_nxt.acc_cin  = ~w_neg_b_nxt;
         end
         S_COMMIT: begin
            w_ctl_nxt.load_divh = AccCout;
            w_ctl_nxt.divh_p    = 1'b0;
            w_ctl_nxt.load_divl = 1'b1;
            w_ctl_nxt.divl_p    = 1'b1;
            w_ctl_nxt.divh_0_p  = AccCout;
         end
         S_FIX: begin
            w_ctl_nxt.load_quot      = 1'b1;
            w_ctl_nxt.inv_result     = w_neg_a_nxt ^ w_neg_b_nxt;
            w_ctl_nxt.result_inv_cin = w_neg_a_nxt ^ w_neg_b_nxt;
            w_ctl_nxt.load_rem       = 1'b1;
            w_ctl_nxt.inv_rem        = w_neg_a_nxt;
         end
         S_DONE: begin
            w_ctl_nxt.done = 1'b1;
         end
         default: begin
            w_ctl_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_ctl  <= '0;
         r_busy <= 1'b0;
      end else if (!Test) begin
         r_ctl  <= w_ctl_nxt;
         r_busy <= w_busy_nxt;
      end
   end

   // A frozen cycle must not act on the array, so the held strobes are masked while Test is high.
   assign w_ctl_out = Test ? '0 : r_ctl;

   assign LOAD_DIVL      = w_ctl_out.load_divl;
   assign LOAD_DIVH      = w_ctl_out.load_divh;
   assign LOAD_ACC       = w_ctl_out.load_acc;
   assign LOAD_QUOT      = w_ctl_out.load_quot;
   assign LOAD_REM       = w_ctl_out.load_rem;
   assign DIVL_P         = w_ctl_out.divl_p;
   assign DIVH_P         = w_ctl_out.divh_p;
   assign DIVH_0_P       = w_ctl_out.divh_0_p;
   assign INV_OP1        = w_ctl_out.inv_op1;
   assign OP1_INV_Cin    = w_ctl_out.op1_inv_cin;
   assign INV_OP2        = w_ctl_out.inv_op2;
   assign ACC_Cin        = w_ctl_out.acc_cin;
   assign INV_RESULT     = w_ctl_out.inv_result;
   assign RESULT_INV_Cin = w_ctl_out.result_inv_cin;
   assign INV_REM        = w_ctl_out.inv_rem;
   assign Done           = w_ctl_out.done;
   assign Busy           = r_busy;
   assign DivZero        = r_div_zero;

endmodule
